// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: 320x240x8 RGB332 buffer doubled to a 640x480@60 VGA stream,
// with front/back buffer selection that only swaps when vertical blanking begins.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] fb_addr,
  output logic        fb_sel,
  input  logic [7:0]  fb_dout,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  LP_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0]  LP_H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  LP_H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  LP_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  LP_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  LP_V_ACT_M1   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  LP_V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  LP_V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  LP_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [16:0] LP_FB_W       = 17'(FB_W);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } swap_state_t;

  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic [16:0] r_row_base;
  logic [16:0] r_fb_addr;
  logic        r_fb_sel;
  logic        r_swap_ack;
  swap_state_t r_swap_state;

  logic        r_s1_active, r_s1_hs, r_s1_vs, r_s1_vb;
  logic        r_s2_active, r_s2_hs, r_s2_vs, r_s2_vb;
  logic        r_hsync, r_vsync, r_vblank;
  logic [3:0]  r_vga_r, r_vga_g, r_vga_b;

  logic        w_line_end;
  logic        w_frame_end;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic        w_vb;
  logic        w_swap_point;
  logic [16:0] w_pix_addr;
  logic [3:0]  w_dec_r, w_dec_g, w_dec_b;

  assign w_line_end  = (r_hcnt == LP_H_LAST);
  assign w_frame_end = w_line_end && (r_vcnt == LP_V_LAST);
  assign w_active    = (r_hcnt < LP_H_ACT) && (r_vcnt < LP_V_ACT);
  assign w_hs        = (r_hcnt >= LP_H_SYNC_BEG) && (r_hcnt <= LP_H_SYNC_END);
  assign w_vs        = (r_vcnt >= LP_V_SYNC_BEG) && (r_vcnt <= LP_V_SYNC_END);
  assign w_vb        = (r_vcnt >= LP_V_ACT);
  assign w_pix_addr  = r_row_base + {8'd0, r_hcnt[9:1]};

  // Decided one clock early so fb_sel/swap_ack change on the very edge the
  // counters enter (0, V_ACTIVE), i.e. the first clock of vertical blanking.
  assign w_swap_point = w_line_end && (r_vcnt == LP_V_ACT_M1);

  assign w_dec_r = {fb_dout[7:5], fb_dout[7]};
  assign w_dec_g = {fb_dout[4:2], fb_dout[4]};
  assign w_dec_b = {fb_dout[1:0], fb_dout[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_row_base <= '0;
    end else begin
      if (w_line_end) begin
        r_hcnt <= '0;
        r_vcnt <= w_frame_end ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
      // Each frame-buffer row feeds two display lines, so advance after odd lines.
      if (w_frame_end) begin
        r_row_base <= '0;
      end else if (w_line_end && r_vcnt[0] && (r_vcnt < LP_V_ACT_M1)) begin
        r_row_base <= r_row_base + LP_FB_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_addr   <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_vb     <= 1'b0;
      r_s2_active <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
      r_s2_vb     <= 1'b0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_vblank    <= 1'b0;
      r_vga_r     <= '0;
      r_vga_g     <= '0;
      r_vga_b     <= '0;
    end else begin
      if (w_active) begin
        r_fb_addr <= w_pix_addr;
      end
      r_s1_active <= w_active;
      r_s1_hs     <= w_hs;
      r_s1_vs     <= w_vs;
      r_s1_vb     <= w_vb;

      r_s2_active <= r_s1_active;
      r_s2_hs     <= r_s1_hs;
      r_s2_vs     <= r_s1_vs;
      r_s2_vb     <= r_s1_vb;

      r_hsync  <= ~r_s2_hs;
      r_vsync  <= ~r_s2_vs;
      r_vblank <= r_s2_vb;
      r_vga_r  <= r_s2_active ? w_dec_r : 4'd0;
      r_vga_g  <= r_s2_active ? w_dec_g : 4'd0;
      r_vga_b  <= r_s2_active ? w_dec_b : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swap_state <= S_IDLE;
      r_fb_sel     <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      case (r_swap_state)
        S_IDLE: begin
          r_swap_ack <= 1'b0;
          if (w_swap_point && swap_req) begin
            r_fb_sel     <= ~r_fb_sel;
            r_swap_ack   <= 1'b1;
            r_swap_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_swap_ack   <= 1'b0;
          r_swap_state <= S_IDLE;
        end
        default: begin
          r_swap_ack   <= 1'b0;
          r_swap_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fb_addr  = r_fb_addr;
  assign fb_sel   = r_fb_sel;
  assign swap_ack = r_swap_ack;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign vblank   = r_vblank;
  assign vga_r    = r_vga_r;
  assign vga_g    = r_vga_g;
  assign vga_b    = r_vga_b;

endmodule
